// File: rtl/apple2_mem_arbiter_if.sv
// Bus bundle between the memory arbiter, the CPU/video front ends and the RAM wrapper.
// slave = arbiter side, master = environment side.
interface apple2_mem_arbiter_if;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic [7:0]  Dl;
    logic        vid_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        phi0;
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        text_mode;
    logic        mix_mode;
    logic        page2;
    logic        hires_mode;

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output Dl, vid_valid, cpu_rdata, cpu_ack, phi0,
               ram_en, ram_we, ram_addr, ram_wdata,
               text_mode, mix_mode, page2, hires_mode
    );

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  Dl, vid_valid, cpu_rdata, cpu_ack, phi0,
               ram_en, ram_we, ram_addr, ram_wdata,
               text_mode, mix_mode, page2, hires_mode
    );
endinterface

// File: rtl/apple2_mem_arbiter.sv
// Apple II style time-slot RAM arbiter: video fetch in the first half of each bus cycle,
// CPU access in the second half. Define ARB_SOFTSWITCH_EN to decode $C050-$C057 as video soft switches.
module apple2_mem_arbiter #(
    parameter int HALF_CYCLES = 24
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    apple2_mem_arbiter_if.slave bus
);
    localparam int FULL_CYCLES = 2 * HALF_CYCLES;
    localparam int CW          = $clog2(FULL_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(FULL_CYCLES - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_CYCLES);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          vid_slot;
    logic          cpu_slot;
    logic          cpu_mem;
    logic          cpu_sw;
    logic          sw_addr;
    logic          vid_pend;
    logic          ack_rd;
    logic [7:0]    rdata_q;

    assign cnt_next = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    assign vid_slot = (cnt == '0) && bus.vid_req;
    assign cpu_slot = (cnt == CNT_HALF) && bus.cpu_req;

`ifdef ARB_SOFTSWITCH_EN
    assign sw_addr = (bus.cpu_addr[15:3] == 13'h180A);
`else
    assign sw_addr = 1'b0;
`endif

    assign cpu_mem = cpu_slot && !sw_addr;
    assign cpu_sw  = cpu_slot && sw_addr;

    // RAM strobes are decoded straight from the slot so the access lands in the slot's first clock;
    // gating with RESET_N drops an in-flight strobe the moment reset asserts.
    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = 16'h0000;
        bus.ram_wdata = 8'h00;
        if (RESET_N) begin
            if (vid_slot) begin
                bus.ram_en   = 1'b1;
                bus.ram_addr = bus.vid_addr;
            end else if (cpu_mem) begin
                bus.ram_en    = 1'b1;
                bus.ram_we    = bus.cpu_we;
                bus.ram_addr  = bus.cpu_addr;
                bus.ram_wdata = bus.cpu_wdata;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt           <= '0;
            bus.phi0      <= 1'b0;
            vid_pend      <= 1'b0;
            bus.vid_valid <= 1'b0;
            bus.Dl        <= 8'h00;
            bus.cpu_ack   <= 1'b0;
            ack_rd        <= 1'b0;
            rdata_q       <= 8'h00;
        end else begin
            cnt           <= cnt_next;
            bus.phi0      <= (cnt_next >= CNT_HALF);
            vid_pend      <= vid_slot;
            bus.vid_valid <= vid_pend;
            if (vid_pend)
                bus.Dl <= bus.ram_rdata;
            bus.cpu_ack <= cpu_slot;
            ack_rd      <= cpu_mem && !bus.cpu_we;
            if (cpu_sw)
                rdata_q <= 8'h00;
            else if (ack_rd)
                rdata_q <= bus.ram_rdata;
        end
    end

    // Read data is forwarded from RAM during the ack clock so it is valid alongside cpu_ack.
    assign bus.cpu_rdata = ack_rd ? bus.ram_rdata : rdata_q;

`ifdef ARB_SOFTSWITCH_EN
    logic text_q;
    logic mix_q;
    logic page2_q;
    logic hires_q;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            text_q  <= 1'b1;
            mix_q   <= 1'b0;
            page2_q <= 1'b0;
            hires_q <= 1'b0;
        end else if (cpu_sw) begin
            case (bus.cpu_addr[2:1])
                2'b00:   text_q  <= bus.cpu_addr[0];
                2'b01:   mix_q   <= bus.cpu_addr[0];
                2'b10:   page2_q <= bus.cpu_addr[0];
                default: hires_q <= bus.cpu_addr[0];
            endcase
        end
    end

    assign bus.text_mode  = text_q;
    assign bus.mix_mode   = mix_q;
    assign bus.page2      = page2_q;
    assign bus.hires_mode = hires_q;
`else
    assign bus.text_mode  = 1'b1;
    assign bus.mix_mode   = 1'b0;
    assign bus.page2      = 1'b0;
    assign bus.hires_mode = 1'b0;
`endif

endmodule

// File: tb/tb_apple2_mem_arbiter.sv
// Self-checking bench for apple2_mem_arbiter: directed scenarios followed by random traffic,
// all compared every clock against a bus-cycle-phase reference model.
module tb_apple2_mem_arbiter;
    localparam int HALF = 24;
    localparam int FULL = 2 * HALF;
`ifdef ARB_SOFTSWITCH_EN
    localparam bit SS_EN = 1'b1;
`else
    localparam bit SS_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    apple2_mem_arbiter_if bus();

    apple2_mem_arbiter #(.HALF_CYCLES(HALF)) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int         phase;
    logic [7:0] m_dl, m_rdata;
    logic       m_text, m_mix, m_page2, m_hires;
    bit         m_vfetch, m_served, m_sw, m_read;
    bit         ack_seen;
    int         ack_phase;
    int         en_count;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_sw(input logic [15:0] a);
        return SS_EN && (a >= 16'hC050) && (a <= 16'hC057);
    endfunction

    task automatic model_reset();
        phase    = 0;
        m_dl     = 8'h00;
        m_rdata  = 8'h00;
        m_text   = 1'b1;
        m_mix    = 1'b0;
        m_page2  = 1'b0;
        m_hires  = 1'b0;
        m_vfetch = 1'b0;
        m_served = 1'b0;
        m_sw     = 1'b0;
        m_read   = 1'b0;
    endtask

    task automatic check_outputs();
        logic        en, we, ack;
        logic [15:0] addr;
        logic [7:0]  wd, rd;
        en = 1'b0; we = 1'b0; addr = 16'h0; wd = 8'h0;
        if (rst_n && phase == 0 && bus.vid_req) begin
            en = 1'b1; addr = bus.vid_addr;
        end else if (rst_n && phase == HALF && bus.cpu_req && !is_sw(bus.cpu_addr)) begin
            en = 1'b1; we = bus.cpu_we; addr = bus.cpu_addr; wd = bus.cpu_wdata;
        end
        ack = (phase == HALF + 1) && m_served;
        rd  = m_rdata;
        if (ack) rd = m_sw ? 8'h00 : (m_read ? bus.ram_rdata : m_rdata);
        chk("ram_en", bus.ram_en, en);
        chk("ram_we", bus.ram_we, we);
        chk("ram_addr", bus.ram_addr, addr);
        chk("ram_wdata", bus.ram_wdata, wd);
        chk("phi0", bus.phi0, phase >= HALF);
        chk("vid_valid", bus.vid_valid, (phase == 2) && m_vfetch);
        chk("Dl", bus.Dl, m_dl);
        chk("cpu_ack", bus.cpu_ack, ack);
        chk("cpu_rdata", bus.cpu_rdata, rd);
        chk("text_mode", bus.text_mode, m_text);
        chk("mix_mode", bus.mix_mode, m_mix);
        chk("page2", bus.page2, m_page2);
        chk("hires_mode", bus.hires_mode, m_hires);
        if (bus.cpu_ack === 1'b1) begin
            ack_seen  = 1'b1;
            ack_phase = phase;
        end
        if (bus.ram_en === 1'b1) en_count++;
    endtask

    task automatic model_tick();
        if (phase == 0) m_vfetch = bus.vid_req;
        if (phase == 1 && m_vfetch) m_dl = bus.ram_rdata;
        if (phase == HALF + 1 && m_served) begin
            if (m_sw) m_rdata = 8'h00;
            else if (m_read) m_rdata = bus.ram_rdata;
            m_served = 1'b0;
        end
        if (phase == HALF) begin
            m_served = bus.cpu_req;
            m_sw     = bus.cpu_req && is_sw(bus.cpu_addr);
            m_read   = bus.cpu_req && !bus.cpu_we && !m_sw;
            if (m_sw) begin
                case (bus.cpu_addr[2:1])
                    2'd0: m_text  = bus.cpu_addr[0];
                    2'd1: m_mix   = bus.cpu_addr[0];
                    2'd2: m_page2 = bus.cpu_addr[0];
                    default: m_hires = bus.cpu_addr[0];
                endcase
            end
        end
        phase = (phase + 1) % FULL;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        if (rst_n) model_tick();
        #1;
    endtask

    task automatic run_to(input int p);
        int guard;
        guard = 0;
        while (phase != p && guard < 2 * FULL) begin
            cycle();
            guard++;
        end
    endtask

    task automatic cpu_access(input string tag, input logic [15:0] a, input logic w, input logic [7:0] d);
        int n;
        bus.cpu_req = 1'b1; bus.cpu_addr = a; bus.cpu_we = w; bus.cpu_wdata = d;
        ack_seen = 1'b0;
        n = 0;
        while (!ack_seen && n < 2 * FULL + 4) begin
            cycle();
            n++;
        end
        chk({tag, "_ack_seen"}, ack_seen, 1'b1);
        bus.cpu_req = 1'b0;
    endtask

    initial begin
        int n, e0;
        bus.vid_req = 1'b1; bus.vid_addr = 16'h0400;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0; bus.cpu_wdata = 8'h0;
        bus.ram_rdata = 8'hA5;
        model_reset();
        ack_seen = 1'b0; ack_phase = -1; en_count = 0;

        // reset hold: everything idle even with vid_req high
        repeat (3) cycle();
        chk("rst_ram_en", bus.ram_en, 1'b0);
        chk("rst_text", bus.text_mode, 1'b1);

        // release and measure phi0 rise
        bus.vid_req = 1'b0;
        rst_n = 1'b1;
        n = 0;
        while (bus.phi0 !== 1'b1 && n < 100) begin
            cycle();
            n++;
        end
        chk("phi0_rise_clocks", 16'(n), 16'd24);

        // video fetch then refetch with new data
        run_to(0);
        bus.vid_req = 1'b1; bus.vid_addr = 16'h0400; bus.ram_rdata = 8'h01;
        cycle(); cycle();
        bus.vid_req = 1'b0;
        chk("vid_dl_01", bus.Dl, 8'h01);
        chk("vid_valid_pulse", bus.vid_valid, 1'b1);
        bus.ram_rdata = 8'h00;
        run_to(0);
        bus.vid_req = 1'b1;
        cycle(); cycle();
        bus.vid_req = 1'b0;
        chk("vid_dl_00", bus.Dl, 8'h00);

        // CPU write then read-back
        run_to(10);
        cpu_access("wr0800", 16'h0800, 1'b1, 8'h41);
        chk("wr_ack_phase", 16'(ack_phase), 16'(HALF + 1));
        bus.ram_rdata = 8'h41;
        cpu_access("rd0800", 16'h0800, 1'b0, 8'h00);
        chk("rd_data_41", bus.cpu_rdata, 8'h41);

        // soft switches
        bus.ram_rdata = 8'h5A;
        e0 = en_count;
        cpu_access("sw_c050", 16'hC050, 1'b1, 8'hFF);
        chk("sw_text", bus.text_mode, SS_EN ? 1'b0 : 1'b1);
        cpu_access("sw_c057", 16'hC057, 1'b0, 8'h00);
        chk("sw_hires", bus.hires_mode, SS_EN ? 1'b1 : 1'b0);
        chk("sw_rdata", bus.cpu_rdata, SS_EN ? 8'h00 : 8'h5A);
        chk("sw_ram_en_count", 16'(en_count - e0), SS_EN ? 16'd0 : 16'd2);

        // late request: raised at cnt=30
        run_to(30);
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h1234; bus.cpu_we = 1'b0;
        ack_seen = 1'b0;
        n = 0;
        while (!ack_seen && n < 200) begin
            cycle();
            if (!ack_seen) n++;
        end
        bus.cpu_req = 1'b0;
        chk("late_ack_clocks", 16'(n), 16'd43);

        // request dropped before sampling point
        run_to(5);
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h3000; bus.cpu_we = 1'b1;
        ack_seen = 1'b0;
        run_to(20);
        bus.cpu_req = 1'b0;
        repeat (FULL) cycle();
        chk("dropped_no_ack", ack_seen, 1'b0);

        // reset in the middle of a CPU access
        cpu_access("sw_c053", 16'hC053, 1'b1, 8'h00);
        run_to(10);
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h2000; bus.cpu_we = 1'b1; bus.cpu_wdata = 8'h77;
        run_to(HALF);
        @(negedge clk);
        chk("mid_ram_en_before", bus.ram_en, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_ram_en_after", bus.ram_en, 1'b0);
        chk("mid_ack", bus.cpu_ack, 1'b0);
        chk("mid_text", bus.text_mode, 1'b1);
        chk("mid_mix", bus.mix_mode, 1'b0);
        model_reset();
        ack_seen = 1'b0;
        repeat (3) cycle();
        bus.cpu_req = 1'b0;
        rst_n = 1'b1;
        repeat (FULL + 5) cycle();
        chk("mid_no_ack", ack_seen, 1'b0);

        // random traffic
        ack_seen = 1'b0;
        repeat (3000) begin
            if (ack_seen) bus.cpu_req = 1'b0;
            ack_seen = 1'b0;
            bus.vid_req   = 1'($urandom % 2);
            bus.vid_addr  = 16'($urandom);
            bus.ram_rdata = 8'($urandom);
            if (!bus.cpu_req && ($urandom % 6 == 0)) begin
                bus.cpu_req   = 1'b1;
                bus.cpu_we    = 1'($urandom % 2);
                bus.cpu_wdata = 8'($urandom);
                bus.cpu_addr  = ($urandom % 3 == 0) ? 16'hC050 + 16'($urandom % 8) : 16'($urandom);
            end else if (bus.cpu_req && phase < HALF && ($urandom % 16 == 0)) begin
                bus.cpu_req = 1'b0;
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
